uart_frame_rx: RTL



---
 rtl/uart_frame_rx.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_rx.sv
// -----------------------------------------------------------------------------
// uart_frame_rx
//
// Receive-side framing stage placed behind a UART RX FIFO. It pops bytes
// through the UART CPU read port, hunts for a sync byte, parses a
// length-prefixed frame, streams the payload to a valid/ready consumer and
// reports per-frame completion or rejection.
//
// Frame format:  SYNC_BYTE, LEN, LEN payload bytes [, CHK]
//   The trailing CHK byte (XOR of LEN and every payload byte) exists only
//   when the macro UART_FRAME_CHECKSUM_EN is defined. Without it the CHK
//   state is absent and frame_done pulses right after the last payload
//   handshake.
//
// Parameters:
//   SYNC_BYTE  frame start marker
//   MAX_LEN    largest legal payload length (1..255)
//   TIMEOUT    inter-byte timeout in clk cycles (>= 2)
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   rx_empty    UART RX FIFO empty flag
//   rx_data     UART data_out, valid the cycle after rx_read
//   rx_read     one-cycle pop strobe to the UART CPU read port
//   m_data      payload byte
//   m_valid     payload byte valid
//   m_ready     consumer accepts the byte
//   m_last      marks the final payload byte of a frame
//   frame_done  one-cycle pulse, frame accepted
//   frame_err   one-cycle pulse, frame rejected or aborted
//   err_count   saturating count of frame_err pulses
// -----------------------------------------------------------------------------
module uart_frame_rx #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned TIMEOUT   = 200000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       rx_read,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_done,
  output logic       frame_err,
  output logic [7:0] err_count
);

  localparam int unsigned   TW        = $clog2(TIMEOUT);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2
`ifdef UART_FRAME_CHECKSUM_EN
    ,
    CHK     = 2'd3
`endif
  } state_t;

  state_t        state;
  state_t        state_next;

  logic          capture;    // rx_data holds the byte popped last cycle
  logic          issue;
  logic          handshake;
  logic          len_bad;
  logic          tmo_hit;
  logic          load_len;
  logic          push_byte;
  logic          done_set;
  logic          err_set;
  logic [7:0]    remaining;
  logic [TW-1:0] tmo_cnt;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]    chk;
`endif

  // A pop is in flight while rx_read is high and during the following
  // capture cycle; holding off while a payload byte waits for the consumer
  // keeps the FIFO as the only buffer, so no skid storage is needed here.
  assign issue     = !rx_read && !capture && !rx_empty && !m_valid;
  assign handshake = m_valid && m_ready;
  assign len_bad   = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);

  // A capture in the same cycle always wins over an expiring timer.
  assign tmo_hit   = (state != HUNT) && !capture && !m_valid && (tmo_cnt == TMO_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and per-cycle decisions
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    load_len   = 1'b0;
    push_byte  = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;

    unique case (state)
      HUNT: begin
        // Anything but the sync byte is line noise and is dropped silently.
        if (capture && (rx_data == SYNC_BYTE)) begin
          state_next = LEN;
        end
      end

      LEN: begin
        // A sync byte here is taken as a length value, never as a restart.
        if (capture) begin
          if (len_bad) begin
            err_set    = 1'b1;
            state_next = HUNT;
          end else begin
            load_len   = 1'b1;
            state_next = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (capture) begin
          push_byte = 1'b1;
        end else if (handshake && m_last) begin
`ifdef UART_FRAME_CHECKSUM_EN
          state_next = CHK;
`else
          done_set   = 1'b1;
          state_next = HUNT;
`endif
        end
      end

`ifdef UART_FRAME_CHECKSUM_EN
      CHK: begin
        if (capture) begin
          if (rx_data == chk) begin
            done_set = 1'b1;
          end else begin
            err_set  = 1'b1;
          end
          state_next = HUNT;
        end
      end
`endif

      default: begin
        state_next = HUNT;
      end
    endcase

    if (tmo_hit) begin
      err_set    = 1'b1;
      state_next = HUNT;
    end
  end

  // ---------------------------------------------------------------------------
  // Read engine, payload output, status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_read    <= 1'b0;
      capture    <= 1'b0;
      m_data     <= 8'd0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      remaining  <= 8'd0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      rx_read    <= issue;
      capture    <= rx_read;
      frame_done <= done_set;
      frame_err  <= err_set;

      if (err_set && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end

      if (load_len) begin
        remaining <= rx_data;
      end

      // m_data/m_last are only rewritten on a new capture, which cannot
      // happen while m_valid is high, so they hold steady until accepted.
      if (push_byte) begin
        m_data    <= rx_data;
        m_valid   <= 1'b1;
        m_last    <= (remaining == 8'd1);
        remaining <= remaining - 8'd1;
      end else if (handshake || tmo_hit) begin
        m_valid   <= 1'b0;
        m_last    <= 1'b0;
      end
    end
  end

`ifdef UART_FRAME_CHECKSUM_EN
  // Running checksum: seeded with LEN, folded with every payload byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk <= 8'd0;
    end else if (load_len) begin
      chk <= rx_data;
    end else if (push_byte) begin
      chk <= chk ^ rx_data;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Inter-byte timeout
  // ---------------------------------------------------------------------------
  // Cleared by every captured byte and whenever the parser is (or is about
  // to be) in HUNT; frozen while a payload byte waits for the consumer, so
  // a slow consumer can never cause an abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (capture || (state_next == HUNT)) begin
      tmo_cnt <= '0;
    end else if (!m_valid) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule
